// File: rtl/recog_pkg.sv
// recog_pkg: shared recognizer state encoding and default widths for match_logger
package recog_pkg;
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  localparam int TS_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/match_fifo.sv
// match_fifo: synchronous FIFO with registered head, full and empty; caller only pushes when there is room
module match_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt, kept, cnt_n;
  logic [W-1:0] head_n;
  // occupancy after the pop and after the push, and the entry that heads the queue next cycle
  always_comb begin
    kept = cnt - (AW+1)'(pop);
    cnt_n = kept + (AW+1)'(push);
    head_n = cnt_n == '0 ? '0 : kept == '0 ? din : mem[rd + AW'(pop)];
  end
  // storage array, written at the tail; no reset needed since head and count gate visibility
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers, occupancy and registered head/status
  always_ff @(posedge clk)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      head <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(push);
      cnt <= cnt_n;
      head <= head_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
endmodule

// File: rtl/match_logger.sv
// match_logger: timestamps each entry into S3 into a FIFO with status counters; MATCH_LOGGER_DROP_CNT_EN adds drop_count
module match_logger
  import recog_pkg::*;
#(
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           s,
  output logic             match,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TS_W-1:0]  out_ts,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
`ifdef MATCH_LOGGER_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_count
`endif
);
  state_t prev_s;
  logic [TS_W-1:0] ts;
  logic empty, full, ev, pop, push, drop;
  assign ev = s == S3 && prev_s != S3 && !reset;
  assign pop = out_valid && out_ready;
  assign push = ev && (!full || pop);
  assign drop = ev && full && !pop;
  assign out_valid = !empty;
  match_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(ts),
    .head(out_ts),
    .full(full),
    .empty(empty)
  );
  // edge detection, free-running timestamp, match pulse, saturating count and sticky overflow
  always_ff @(posedge clk)
    if (reset) begin
      prev_s <= S0;
      ts <= '0;
      match <= 1'b0;
      match_count <= '0;
      overflow <= 1'b0;
    end else begin
      prev_s <= s;
      ts <= ts + 1'b1;
      match <= ev;
      if (ev && !(&match_count)) match_count <= match_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
`ifdef MATCH_LOGGER_DROP_CNT_EN
  // saturating count of events lost to a full FIFO
  always_ff @(posedge clk)
    if (reset) drop_count <= '0;
    else if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
`endif
endmodule

// File: tb/tb_match_logger.sv
// tb_match_logger: directed self-checking bench for match_logger (default and narrow-width instances)
module tb_match_logger;
  import recog_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  state_t s = S0;
  state_t s2 = S0;
  logic out_ready = 1'b0;
  logic out_ready2 = 1'b0;
  logic match, out_valid, overflow;
  logic [15:0] out_ts;
  logic [7:0] match_count;
  logic match2, out_valid2, overflow2;
  logic [3:0] out_ts2;
  logic [1:0] match_count2;
`ifdef MATCH_LOGGER_DROP_CNT_EN
  logic [7:0] drop_count;
  logic [1:0] drop_count2;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  match_logger dut (
    .clk(clk), .reset(reset), .s(s), .match(match), .out_valid(out_valid),
    .out_ready(out_ready), .out_ts(out_ts), .match_count(match_count), .overflow(overflow)
`ifdef MATCH_LOGGER_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .s(s2), .match(match2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_ts(out_ts2), .match_count(match_count2), .overflow(overflow2)
`ifdef MATCH_LOGGER_DROP_CNT_EN
    , .drop_count(drop_count2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s = S0;
    s2 = S0;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %0b exp 0", match); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_ts !== 16'd0) begin errors++; $display("FAIL reset_ts got %0d exp 0", out_ts); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", match_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
  endtask

  task automatic test_basic_match();
    do_reset();
    s = S0; tick();
    s = S1; tick();
    s = S2; tick();
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL basic_premature got %0b exp 0", match); end
    s = S3; tick();
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL basic_match got %0b exp 1", match); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
    checks++; if (out_ts !== 16'd3) begin errors++; $display("FAIL basic_ts got %0d exp 3", out_ts); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", match_count); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL hold_match[%0d] got %0b exp 0", i, match); end
      checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL hold_count[%0d] got %0d exp 1", i, match_count); end
    end
    checks++; if (out_ts !== 16'd3) begin errors++; $display("FAIL hold_ts got %0d exp 3", out_ts); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s = S3; tick();
      checks++; if (overflow !== (i == 4)) begin errors++; $display("FAIL ovf_flag[%0d] got %0b exp %0b", i, overflow, i == 4); end
      s = S0; tick();
    end
    checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL ovf_count got %0d exp 5", match_count); end
`ifdef MATCH_LOGGER_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", drop_count); end
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d] got %0b exp 1", i, out_valid); end
      checks++; if (out_ts !== 16'(2 * i)) begin errors++; $display("FAIL ovf_order[%0d] got %0d exp %0d", i, out_ts, 2 * i); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b exp 0", out_valid); end
    checks++; if (out_ts !== 16'd0) begin errors++; $display("FAIL ovf_empty_ts got %0d exp 0", out_ts); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = S3; tick();
      s = S0; tick();
    end
    s = S3; out_ready = 1'b1; tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %0b exp 0", overflow); end
    checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL fpp_count got %0d exp 5", match_count); end
    s = S0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fpp_valid[%0d] got %0b exp 1", i, out_valid); end
      checks++; if (out_ts !== 16'(2 + 2 * i)) begin errors++; $display("FAIL fpp_order[%0d] got %0d exp %0d", i, out_ts, 2 + 2 * i); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_drained got %0b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s = S3; tick();
      s = S0; tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_queued got %0b exp 1", out_valid); end
    reset = 1'b1; s = S3; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b exp 0", out_valid); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", match_count); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL mrst_match got %0b exp 0", match); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mrst_overflow got %0b exp 0", overflow); end
    reset = 1'b0; tick();
    checks++; if (out_ts !== 16'd0) begin errors++; $display("FAIL mrst_ts0 got %0d exp 0", out_ts); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL mrst_count1 got %0d exp 1", match_count); end
    s = S0; tick();
    s = S3; tick();
    s = S0; out_ready = 1'b1; tick();
    checks++; if (out_ts !== 16'd2) begin errors++; $display("FAIL mrst_ts2 got %0d exp 2", out_ts); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) tick();
    s2 = S3; tick();
    checks++; if (out_ts2 !== 4'd1) begin errors++; $display("FAIL wrap_ts got %0d exp 1", out_ts2); end
    checks++; if (match2 !== 1'b1) begin errors++; $display("FAIL wrap_match got %0b exp 1", match2); end
    for (int i = 0; i < 4; i++) begin
      s2 = S0; tick();
      s2 = S3; tick();
      if (i == 1) begin
        checks++; if (match_count2 !== 2'd3) begin errors++; $display("FAIL sat_count3 got %0d exp 3", match_count2); end
      end
    end
    checks++; if (match_count2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", match_count2); end
    checks++; if (overflow2 !== 1'b1) begin errors++; $display("FAIL sat_overflow got %0b exp 1", overflow2); end
    s2 = S0;
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_overflow();
    test_full_push_pop();
    test_mid_reset();
    test_wrap_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
